// File: rtl/cis_sequencer_if.sv
// Bundle between the register bank, the CIS readout sequencer and the sensor clock drivers.
// The master side owns the configuration and the integration level. The slave side owns the waveforms.
interface cis_sequencer_if #(
  parameter int NUM_SIGNALS = 10,
  parameter int MAX_LEN     = 64,
  parameter int LEN_W       = $clog2(MAX_LEN + 1),
  parameter int SKIP_W      = 14,
  parameter int DIV_W       = 10
);
  logic [DIV_W-1:0]               clk_div;
  logic                           integration;
  logic [LEN_W-1:0]               len_rst;
  logic [LEN_W-1:0]               len_int;
  logic [LEN_W-1:0]               len_skip;
  logic [SKIP_W-1:0]              skip_samples;
  logic [LEN_W-1:0]               phi_base_step;
  logic [LEN_W-1:0]               phi_sig_step;
  logic [MAX_LEN*NUM_SIGNALS-1:0] pat_rst;
  logic [MAX_LEN*NUM_SIGNALS-1:0] pat_int;
  logic [MAX_LEN*NUM_SIGNALS-1:0] pat_skip;
  logic [NUM_SIGNALS-1:0]         signal;
  logic                           phi_base;
  logic                           phi_sig;
  logic [SKIP_W-1:0]              sample_idx;
  logic                           busy;
  logic                           done;
  logic                           cfg_err;

  modport master (
    output clk_div, integration, len_rst, len_int, len_skip, skip_samples,
           phi_base_step, phi_sig_step, pat_rst, pat_int, pat_skip,
    input  signal, phi_base, phi_sig, sample_idx, busy, done, cfg_err
  );

  modport slave (
    input  clk_div, integration, len_rst, len_int, len_skip, skip_samples,
           phi_base_step, phi_sig_step, pat_rst, pat_int, pat_skip,
    output signal, phi_base, phi_sig, sample_idx, busy, done, cfg_err
  );
endinterface

// File: rtl/cis_sequencer.sv
// CIS readout sequencer: plays CCD reset, integration and repeated skipper readout patterns,
// one step per clock-divider tick, with baseline/signal sample strobes for the FE/ADC.
//
// state   | meaning
// IDLE    | waiting for an integration rise; lines held at 0
// CCD_RST | playing the CCD reset pattern
// INTEG   | playing the integration pattern, then holding its last word until integration ends
// SKIP    | playing the skip pattern skip_samples times
// DONE    | one step with lines at 0 before returning to IDLE
module cis_sequencer #(
  parameter int NUM_SIGNALS = 10,
  parameter int MAX_LEN     = 64,
  parameter int LEN_W       = $clog2(MAX_LEN + 1),
  parameter int SKIP_W      = 14,
  parameter int DIV_W       = 10
) (
  input  logic          clk,
  input  logic          reset,
  cis_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, CCD_RST, INTEG, SKIP, DONE} state_t;

  state_t state, state_nxt;
  logic [LEN_W-1:0]  step, step_nxt;
  logic [SKIP_W-1:0] rep, rep_nxt;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              integ_q, rise_pend, fall_seen;
  logic              rise, fall, start_req, cfg_bad, start_ok;

  logic [LEN_W-1:0]  len_rst_s, len_int_s, len_skip_s, base_step_s, sig_step_s;
  logic [SKIP_W-1:0] skip_s;

  logic [NUM_SIGNALS-1:0] signal_nxt;
  logic phi_base_nxt, phi_sig_nxt, done_nxt, cfg_err_nxt;

  logic [NUM_SIGNALS-1:0] rst_w  [MAX_LEN];
  logic [NUM_SIGNALS-1:0] int_w  [MAX_LEN];
  logic [NUM_SIGNALS-1:0] skip_w [MAX_LEN];

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_words
    assign rst_w[i]  = bus.pat_rst[i*NUM_SIGNALS +: NUM_SIGNALS];
    assign int_w[i]  = bus.pat_int[i*NUM_SIGNALS +: NUM_SIGNALS];
    assign skip_w[i] = bus.pat_skip[i*NUM_SIGNALS +: NUM_SIGNALS];
  end

  function automatic logic len_bad(input logic [LEN_W-1:0] len);
    return (len == '0) || (len > MAX_LEN_L);
  endfunction

  assign tick      = (div_cnt == bus.clk_div);
  assign rise      = bus.integration & ~integ_q;
  assign fall      = ~bus.integration & integ_q;
  assign start_req = rise | rise_pend;
  assign cfg_bad   = len_bad(bus.len_rst) | len_bad(bus.len_int) | len_bad(bus.len_skip);
  assign start_ok  = tick && (state == IDLE) && start_req && !cfg_bad;

  // Divider, integration edge tracking and shadow configuration run on every clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      integ_q     <= 1'b0;
      rise_pend   <= 1'b0;
      fall_seen   <= 1'b0;
      len_rst_s   <= '0;
      len_int_s   <= '0;
      len_skip_s  <= '0;
      skip_s      <= '0;
      base_step_s <= '0;
      sig_step_s  <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      integ_q <= bus.integration;
      if (tick)
        rise_pend <= 1'b0;
      else if (state == IDLE && rise)
        rise_pend <= 1'b1;
      if (start_ok)
        fall_seen <= 1'b0;
      else if ((state == CCD_RST || state == INTEG) && fall)
        fall_seen <= 1'b1;
      if (start_ok) begin
        len_rst_s   <= bus.len_rst;
        len_int_s   <= bus.len_int;
        len_skip_s  <= bus.len_skip;
        skip_s      <= bus.skip_samples;
        base_step_s <= bus.phi_base_step;
        sig_step_s  <= bus.phi_sig_step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      rep   <= '0;
    end else if (tick) begin
      state <= state_nxt;
      step  <= step_nxt;
      rep   <= rep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    rep_nxt   = rep;
    case (state)
      IDLE: begin
        if (start_req && !cfg_bad) begin
          state_nxt = CCD_RST;
          step_nxt  = '0;
          rep_nxt   = '0;
        end
      end
      CCD_RST: begin
        if (step == len_rst_s - 1'b1) begin
          state_nxt = INTEG;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      INTEG: begin
        if (step != len_int_s - 1'b1) begin
          step_nxt = step + 1'b1;
        end else if (fall_seen || !bus.integration) begin
          step_nxt  = '0;
          rep_nxt   = '0;
          state_nxt = (skip_s != '0) ? SKIP : DONE;
        end
      end
      SKIP: begin
        if (step == len_skip_s - 1'b1) begin
          step_nxt = '0;
          if (rep == skip_s - 1'b1) begin
            state_nxt = DONE;
            rep_nxt   = '0;
          end else begin
            rep_nxt = rep + 1'b1;
          end
        end else begin
          step_nxt = step + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the step being entered; registered on the tick.
  always_comb begin
    signal_nxt   = '0;
    phi_base_nxt = 1'b0;
    phi_sig_nxt  = 1'b0;
    done_nxt     = 1'b0;
    case (state_nxt)
      CCD_RST: signal_nxt = rst_w[step_nxt[IDX_W-1:0]];
      INTEG:   signal_nxt = int_w[step_nxt[IDX_W-1:0]];
      SKIP: begin
        signal_nxt   = skip_w[step_nxt[IDX_W-1:0]];
        phi_base_nxt = (step_nxt == base_step_s);
        phi_sig_nxt  = (step_nxt == sig_step_s);
      end
      DONE:    done_nxt = 1'b1;
      default: signal_nxt = '0;
    endcase
    cfg_err_nxt = (state == IDLE) && start_req && cfg_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.signal     <= '0;
      bus.phi_base   <= 1'b0;
      bus.phi_sig    <= 1'b0;
      bus.sample_idx <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.cfg_err    <= 1'b0;
    end else begin
      bus.done    <= tick & done_nxt;
      bus.cfg_err <= tick & cfg_err_nxt;
      if (tick) begin
        bus.signal     <= signal_nxt;
        bus.phi_base   <= phi_base_nxt;
        bus.phi_sig    <= phi_sig_nxt;
        bus.sample_idx <= rep_nxt;
        bus.busy       <= (state_nxt != IDLE);
      end
    end
  end
endmodule
